// File: rtl/matrix_stream_loader.sv
// Parses a valid/ready stream of burst headers and row words. Each burst becomes
// one-hot row writes on NUM_CH storage write ports, preceded by a locator reset pulse.
module matrix_stream_loader #(
    parameter int DATA_W = 48,
    parameter int IDX_W  = 32,
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              abort,
    output logic [DATA_W-1:0] wr_data,
    output logic [IDX_W-1:0]  wr_layer_index,
    output logic [IDX_W-1:0]  wr_row_index,
    output logic [NUM_CH-1:0] wr_is_write,
    output logic              locator_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCRST = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CH_W-1:0]  hdr_ch_p0;
    logic [IDX_W-1:0] hdr_layer_p0;
    logic [CNT_W-1:0] hdr_rows_p0;
    logic [CNT_W-1:0] row_cnt_p0;
    logic             vld_p0;
    logic             last_beat;

    function automatic logic hdr_valid(input logic [DATA_W-1:0] w);
        return (w[47:40] == 8'hA5) && (w[39:32] < 8'(NUM_CH));
    endfunction

    assign vld_p0    = s_valid & s_ready;
    assign last_beat = (row_cnt_p0 == hdr_rows_p0 - CNT_W'(1));

    always_comb begin
        state_d       = state_q;
        s_ready       = 1'b0;
        locator_reset = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        case (state_q)
            IDLE: begin
                busy    = 1'b0;
                s_ready = ~abort;
                if (vld_p0 && hdr_valid(s_data))
                    state_d = (s_data[15:0] == 16'd0) ? DONE : LOCRST;
            end
            LOCRST: begin
                locator_reset = 1'b1;
                state_d       = STREAM;
            end
            STREAM: begin
                s_ready = ~abort;
                if (vld_p0 && last_beat)
                    state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort)
            state_d = IDLE;
        // While reset is held nothing may look ready, even though the state is IDLE.
        if (!reset_reset_n)
            s_ready = 1'b0;
    end

    // Stage p0 -> outputs: header latch, row counter and registered write strobe
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q        <= IDLE;
            hdr_ch_p0      <= '0;
            hdr_layer_p0   <= '0;
            hdr_rows_p0    <= '0;
            row_cnt_p0     <= '0;
            wr_data        <= '0;
            wr_layer_index <= '0;
            wr_row_index   <= '0;
            wr_is_write    <= '0;
            err            <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_is_write <= '0;
            if (abort) begin
                err <= 1'b0;
            end else if (vld_p0 && state_q == IDLE) begin
                if (hdr_valid(s_data)) begin
                    hdr_ch_p0    <= CH_W'(s_data[39:32]);
                    hdr_layer_p0 <= IDX_W'(s_data[31:16]);
                    hdr_rows_p0  <= CNT_W'(s_data[15:0]);
                    row_cnt_p0   <= '0;
                end else begin
                    err <= 1'b1;
                end
            end else if (vld_p0 && state_q == STREAM) begin
                wr_data        <= s_data;
                wr_row_index   <= IDX_W'(row_cnt_p0);
                wr_layer_index <= hdr_layer_p0;
                wr_is_write    <= NUM_CH'(1) << hdr_ch_p0;
                row_cnt_p0     <= row_cnt_p0 + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed bench for matrix_stream_loader: a cycle table covering the burst
// scenarios, plus hand-written async-reset sequences.
module tb_matrix_stream_loader;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [47:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        abort;
    logic [47:0] wr_data;
    logic [31:0] wr_layer_index;
    logic [31:0] wr_row_index;
    logic [3:0]  wr_is_write;
    logic        locator_reset;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;

    matrix_stream_loader dut (
        .clk_clk        (clk_clk),
        .reset_reset_n  (reset_reset_n),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .abort          (abort),
        .wr_data        (wr_data),
        .wr_layer_index (wr_layer_index),
        .wr_row_index   (wr_row_index),
        .wr_is_write    (wr_is_write),
        .locator_reset  (locator_reset),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct {
        logic [47:0] data;
        logic        valid;
        logic        abrt;
        logic        rdy;
        logic        lr;
        logic        bsy;
        logic        dn;
        logic        er;
        logic [3:0]  wr;
        logic [31:0] row;
        logic [47:0] wd;
        logic [31:0] lay;
    } vec_t;

    localparam int NVEC = 42;
    vec_t tbl [NVEC];

    function automatic logic [47:0] hdr(input int ch, input int layer, input int n);
        return {8'hA5, 8'(ch), 16'(layer), 16'(n)};
    endfunction

    function automatic logic [47:0] rw(input int k);
        return 48'hBEEF_0000_0000 | 48'(k);
    endfunction

    function automatic vec_t mk(input logic [47:0] data, input logic valid, input logic abrt,
                                input logic rdy, input logic lr, input logic bsy, input logic dn,
                                input logic er, input logic [3:0] wr, input int row,
                                input logic [47:0] wd, input int lay);
        vec_t v;
        v.data = data; v.valid = valid; v.abrt = abrt;
        v.rdy = rdy; v.lr = lr; v.bsy = bsy; v.dn = dn; v.er = er;
        v.wr = wr; v.row = 32'(row); v.wd = wd; v.lay = 32'(lay);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic rdy, input logic lr, input logic bsy,
                           input logic dn, input logic er, input logic [3:0] wr,
                           input logic [31:0] row, input logic [47:0] wd, input logic [31:0] lay);
        chk({tag, " s_ready"},        64'(s_ready),        64'(rdy));
        chk({tag, " locator_reset"},  64'(locator_reset),  64'(lr));
        chk({tag, " busy"},           64'(busy),           64'(bsy));
        chk({tag, " done"},           64'(done),           64'(dn));
        chk({tag, " err"},            64'(err),            64'(er));
        chk({tag, " wr_is_write"},    64'(wr_is_write),    64'(wr));
        chk({tag, " wr_row_index"},   64'(wr_row_index),   64'(row));
        chk({tag, " wr_data"},        64'(wr_data),        64'(wd));
        chk({tag, " wr_layer_index"}, 64'(wr_layer_index), 64'(lay));
    endtask

    task automatic drive(input logic [47:0] d, input logic v, input logic a);
        s_data  = d;
        s_valid = v;
        abort   = a;
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    initial begin
        // T1: ch1 / layer 2 / 3 rows back-to-back
        tbl[0]  = mk(hdr(1, 2, 3), 1, 0,  1, 0, 0, 0, 0, 4'b0000, 0, 48'h0, 0);
        tbl[1]  = mk(48'h0,        0, 0,  0, 1, 1, 0, 0, 4'b0000, 0, 48'h0, 0);
        tbl[2]  = mk(rw(0),        1, 0,  1, 0, 1, 0, 0, 4'b0000, 0, 48'h0, 0);
        tbl[3]  = mk(rw(1),        1, 0,  1, 0, 1, 0, 0, 4'b0010, 0, rw(0), 2);
        tbl[4]  = mk(rw(2),        1, 0,  1, 0, 1, 0, 0, 4'b0010, 1, rw(1), 2);
        tbl[5]  = mk(48'h0,        0, 0,  0, 0, 1, 1, 0, 4'b0010, 2, rw(2), 2);
        tbl[6]  = mk(48'h0,        0, 0,  1, 0, 0, 0, 0, 4'b0000, 2, rw(2), 2);
        // T2: ch0 / layer 7 / 4 rows with 2-cycle gaps
        tbl[7]  = mk(hdr(0, 7, 4), 1, 0,  1, 0, 0, 0, 0, 4'b0000, 2, rw(2), 2);
        tbl[8]  = mk(48'h0,        0, 0,  0, 1, 1, 0, 0, 4'b0000, 2, rw(2), 2);
        tbl[9]  = mk(rw(10),       1, 0,  1, 0, 1, 0, 0, 4'b0000, 2, rw(2), 2);
        tbl[10] = mk(48'h0,        0, 0,  1, 0, 1, 0, 0, 4'b0001, 0, rw(10), 7);
        tbl[11] = mk(48'h0,        0, 0,  1, 0, 1, 0, 0, 4'b0000, 0, rw(10), 7);
        tbl[12] = mk(rw(11),       1, 0,  1, 0, 1, 0, 0, 4'b0000, 0, rw(10), 7);
        tbl[13] = mk(48'h0,        0, 0,  1, 0, 1, 0, 0, 4'b0001, 1, rw(11), 7);
        tbl[14] = mk(48'h0,        0, 0,  1, 0, 1, 0, 0, 4'b0000, 1, rw(11), 7);
        tbl[15] = mk(rw(12),       1, 0,  1, 0, 1, 0, 0, 4'b0000, 1, rw(11), 7);
        tbl[16] = mk(48'h0,        0, 0,  1, 0, 1, 0, 0, 4'b0001, 2, rw(12), 7);
        tbl[17] = mk(48'h0,        0, 0,  1, 0, 1, 0, 0, 4'b0000, 2, rw(12), 7);
        tbl[18] = mk(rw(13),       1, 0,  1, 0, 1, 0, 0, 4'b0000, 2, rw(12), 7);
        tbl[19] = mk(48'h0,        0, 0,  0, 0, 1, 1, 0, 4'b0001, 3, rw(13), 7);
        tbl[20] = mk(48'h0,        0, 0,  1, 0, 0, 0, 0, 4'b0000, 3, rw(13), 7);
        // T3: bad magic, then ch2 / layer 9 / 1 row
        tbl[21] = mk(48'h5A02_0005_0001, 1, 0, 1, 0, 0, 0, 0, 4'b0000, 3, rw(13), 7);
        tbl[22] = mk(hdr(2, 9, 1), 1, 0,  1, 0, 0, 0, 1, 4'b0000, 3, rw(13), 7);
        tbl[23] = mk(48'h0,        0, 0,  0, 1, 1, 0, 1, 4'b0000, 3, rw(13), 7);
        tbl[24] = mk(rw(20),       1, 0,  1, 0, 1, 0, 1, 4'b0000, 3, rw(13), 7);
        tbl[25] = mk(48'h0,        0, 0,  0, 0, 1, 1, 1, 4'b0100, 0, rw(20), 9);
        tbl[26] = mk(48'h0,        0, 0,  1, 0, 0, 0, 1, 4'b0000, 0, rw(20), 9);
        // T4: N=0 on ch3, then out-of-range channel 4
        tbl[27] = mk(hdr(3, 4, 0), 1, 0,  1, 0, 0, 0, 1, 4'b0000, 0, rw(20), 9);
        tbl[28] = mk(48'h0,        0, 0,  0, 0, 1, 1, 1, 4'b0000, 0, rw(20), 9);
        tbl[29] = mk(hdr(4, 1, 2), 1, 0,  1, 0, 0, 0, 1, 4'b0000, 0, rw(20), 9);
        tbl[30] = mk(48'h0,        0, 0,  1, 0, 0, 0, 1, 4'b0000, 0, rw(20), 9);
        // T5: ch0 / layer 5 / 5 rows, abort after row 1, then a normal burst
        tbl[31] = mk(hdr(0, 5, 5), 1, 0,  1, 0, 0, 0, 1, 4'b0000, 0, rw(20), 9);
        tbl[32] = mk(48'h0,        0, 0,  0, 1, 1, 0, 1, 4'b0000, 0, rw(20), 9);
        tbl[33] = mk(rw(30),       1, 0,  1, 0, 1, 0, 1, 4'b0000, 0, rw(20), 9);
        tbl[34] = mk(rw(31),       1, 0,  1, 0, 1, 0, 1, 4'b0001, 0, rw(30), 5);
        tbl[35] = mk(rw(32),       1, 1,  0, 0, 1, 0, 1, 4'b0001, 1, rw(31), 5);
        tbl[36] = mk(48'h0,        0, 0,  1, 0, 0, 0, 0, 4'b0000, 1, rw(31), 5);
        tbl[37] = mk(hdr(1, 6, 1), 1, 0,  1, 0, 0, 0, 0, 4'b0000, 1, rw(31), 5);
        tbl[38] = mk(48'h0,        0, 0,  0, 1, 1, 0, 0, 4'b0000, 1, rw(31), 5);
        tbl[39] = mk(rw(40),       1, 0,  1, 0, 1, 0, 0, 4'b0000, 1, rw(31), 5);
        tbl[40] = mk(48'h0,        0, 0,  0, 0, 1, 1, 0, 4'b0010, 0, rw(40), 6);
        tbl[41] = mk(48'h0,        0, 0,  1, 0, 0, 0, 0, 4'b0000, 0, rw(40), 6);

        reset_reset_n = 1'b1;
        drive(48'h0, 1'b0, 1'b0);
        #1 reset_reset_n = 1'b0;
        #1;
        chk_all("reset", 0, 0, 0, 0, 0, 4'b0000, 0, 48'h0, 0);

        @(posedge clk_clk);
        @(posedge clk_clk);
        #1 reset_reset_n = 1'b1;
        tick();

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].data, tbl[i].valid, tbl[i].abrt);
            #1;
            chk_all($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].lr, tbl[i].bsy, tbl[i].dn,
                    tbl[i].er, tbl[i].wr, tbl[i].row, tbl[i].wd, tbl[i].lay);
            @(posedge clk_clk);
            #1;
        end

        // T6: set err, start a burst, then drop reset asynchronously mid-STREAM
        drive(48'h1203_0000_0002, 1'b1, 1'b0);
        tick();
        chk("t6 err set", 64'(err), 64'(1));
        drive(hdr(2, 3, 4), 1'b1, 1'b0);
        tick();
        drive(48'h0, 1'b0, 1'b0);
        tick();
        drive(rw(50), 1'b1, 1'b0);
        tick();
        drive(rw(51), 1'b1, 1'b0);
        tick();
        drive(48'h0, 1'b0, 1'b0);
        chk("t6 pre-reset strobe", 64'(wr_is_write), 64'(4'b0100));
        chk("t6 pre-reset row", 64'(wr_row_index), 64'(1));
        #2 reset_reset_n = 1'b0;
        #1;
        chk_all("t6 in reset", 0, 0, 0, 0, 0, 4'b0000, 0, 48'h0, 0);
        #2 reset_reset_n = 1'b1;
        tick();
        chk("t6 idle ready", 64'(s_ready), 64'(1));
        drive(hdr(2, 3, 2), 1'b1, 1'b0);
        tick();
        chk("t6 locator_reset", 64'(locator_reset), 64'(1));
        drive(48'h0, 1'b0, 1'b0);
        tick();
        drive(rw(60), 1'b1, 1'b0);
        tick();
        drive(rw(61), 1'b1, 1'b0);
        #1;
        chk_all("t6 row0", 1, 0, 1, 0, 0, 4'b0100, 0, rw(60), 3);
        @(posedge clk_clk);
        #1;
        drive(48'h0, 1'b0, 1'b0);
        #1;
        chk_all("t6 row1", 0, 0, 1, 1, 0, 4'b0100, 1, rw(61), 3);
        tick();
        chk_all("t6 idle", 1, 0, 0, 0, 0, 4'b0000, 1, rw(61), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
